// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: ID-stage operand forwarding selects, load-use
// interlock, multi-cycle mul/div occupancy tracking and a saturating stall
// counter. The mul/div unit is modelled as an IDLE/BUSY FSM with a down-counter.
module pipe_hazard_ctrl #(
    parameter int MD_LAT = 32
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [4:0]  drs,
    input  logic [4:0]  drt,
    input  logic        d_use_rs,
    input  logic        d_use_rt,
    input  logic        d_muldiv,
    input  logic        d_mfhilo,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic [4:0]  ern,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic [4:0]  mrn,
    output logic        wpcir,
    output logic        dbubble,
    output logic [1:0]  fwda,
    output logic [1:0]  fwdb,
    output logic        md_start,
    output logic        md_busy,
    output logic        md_done,
    output logic [15:0] stall_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(MD_LAT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic [15:0] r_stall_cnt;

    logic        w_e_alu_ok;   // EX holds a nonzero ALU destination
    logic        w_e_ld_ok;    // EX holds a nonzero load destination
    logic        w_m_wr_ok;    // MEM writes a nonzero destination
    logic        w_lu;
    logic        w_mdh;
    logic        w_stall;

    // Register 0 is hardwired, so a write to it never creates a dependence.
    assign w_e_alu_ok = ewreg & ~em2reg & (ern != 5'd0);
    assign w_e_ld_ok  = ewreg &  em2reg & (ern != 5'd0);
    assign w_m_wr_ok  = mwreg & (mrn != 5'd0);

    // Select the youngest producer of a source register; EX beats MEM.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic       e_alu_ok,
                                           input logic [4:0] e_rn,
                                           input logic       m_wr_ok,
                                           input logic       m_ld,
                                           input logic [4:0] m_rn);
        logic [1:0] sel;
        sel = 2'b00;
        if (e_alu_ok && (e_rn == src)) begin
            sel = 2'b01;
        end else if (m_wr_ok && (m_rn == src)) begin
            sel = m_ld ? 2'b11 : 2'b10;
        end
        return sel;
    endfunction

    assign fwda = fwd_sel(drs, w_e_alu_ok, ern, w_m_wr_ok, mm2reg, mrn);
    assign fwdb = fwd_sel(drt, w_e_alu_ok, ern, w_m_wr_ok, mm2reg, mrn);

    // A load in EX cannot forward in time to a dependent ID instruction.
    assign w_lu = w_e_ld_ok & ((d_use_rs & (ern == drs)) | (d_use_rt & (ern == drt)));

    assign md_busy = (r_state == BUSY);
    assign md_done = md_busy & (r_cnt == 8'd0);

    // HI/LO readers and new mul/div ops wait out the whole occupancy, done cycle included.
    assign w_mdh    = md_busy & (d_muldiv | d_mfhilo);
    assign w_stall  = w_lu | w_mdh;
    assign wpcir    = ~w_stall;
    assign dbubble  = w_stall;

    // A load-use stall withholds issue so the mul/div never starts on stale operands.
    assign md_start = d_muldiv & ~md_busy & ~w_lu;

    assign stall_cnt = r_stall_cnt;

    // Mul/div occupancy FSM: next-state and counter decode.
    always_comb begin
        // NOTE: every always_comb target gets a default first, otherwise paths that skip an assignment infer a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (md_start) begin
                    w_state_nxt = BUSY;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Mul/div occupancy FSM: state and counter registers; reset aborts any operation.
    always_ff @(posedge clk or posedge clrn) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (clrn) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Count stall cycles, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a vector table for forwarding and
// load-use decode, hand-written multi-cycle sequences for mul/div timing and
// reset, randomized traffic against a cycle-level reference model, and a long
// stall run for counter saturation.
module tb_pipe_hazard_ctrl;

    localparam int MD_LAT = 32;

    logic        clk;
    logic        clrn;
    logic [4:0]  drs, drt, ern, mrn;
    logic        d_use_rs, d_use_rt, d_muldiv, d_mfhilo;
    logic        ewreg, em2reg, mwreg, mm2reg;
    logic        wpcir, dbubble, md_start, md_busy, md_done;
    logic [1:0]  fwda, fwdb;
    logic [15:0] stall_cnt;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: remaining busy cycles of the mul/div unit and total stalls seen.
    int m_rem    = 0;
    int m_stalls = 0;

    pipe_hazard_ctrl #(.MD_LAT(MD_LAT)) dut (
        .clk      (clk),
        .clrn     (clrn),
        .drs      (drs),
        .drt      (drt),
        .d_use_rs (d_use_rs),
        .d_use_rt (d_use_rt),
        .d_muldiv (d_muldiv),
        .d_mfhilo (d_mfhilo),
        .ewreg    (ewreg),
        .em2reg   (em2reg),
        .ern      (ern),
        .mwreg    (mwreg),
        .mm2reg   (mm2reg),
        .mrn      (mrn),
        .wpcir    (wpcir),
        .dbubble  (dbubble),
        .fwda     (fwda),
        .fwdb     (fwdb),
        .md_start (md_start),
        .md_busy  (md_busy),
        .md_done  (md_done),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (rule level) ----------------
    function automatic logic [1:0] m_fwd(input logic [4:0] src);
        if (ewreg && !em2reg && ern != 5'd0 && ern == src) return 2'b01;
        if (mwreg && mrn != 5'd0 && mrn == src) return mm2reg ? 2'b11 : 2'b10;
        return 2'b00;
    endfunction

    function automatic logic m_lu();
        return ewreg && em2reg && ern != 5'd0 &&
               ((d_use_rs && ern == drs) || (d_use_rt && ern == drt));
    endfunction

    function automatic logic m_busy();
        return m_rem > 0;
    endfunction

    function automatic logic m_stall();
        return m_lu() || (m_busy() && (d_muldiv || d_mfhilo));
    endfunction

    function automatic logic m_start();
        return d_muldiv && !m_busy() && !m_lu();
    endfunction

    function automatic logic [15:0] m_cnt();
        return (m_stalls > 65535) ? 16'hFFFF : 16'(m_stalls);
    endfunction

    // Compare every output against the model.
    task automatic cmp_all(input string tag);
        check({tag, ".fwda"},     32'(fwda),      32'(m_fwd(drs)));
        check({tag, ".fwdb"},     32'(fwdb),      32'(m_fwd(drt)));
        check({tag, ".wpcir"},    32'(wpcir),     32'(!m_stall()));
        check({tag, ".dbubble"},  32'(dbubble),   32'(m_stall()));
        check({tag, ".md_start"}, 32'(md_start),  32'(m_start()));
        check({tag, ".md_busy"},  32'(md_busy),   32'(m_busy()));
        check({tag, ".md_done"},  32'(md_done),   32'(m_rem == 1));
        check({tag, ".stall_cnt"},32'(stall_cnt), 32'(m_cnt()));
    endtask

    // Advance one clock; the model consumes the same inputs the DUT saw at the edge.
    task automatic tick();
        logic st, stl;
        st  = m_start();
        stl = m_stall();
        @(posedge clk);
        if (clrn) begin
            m_rem    = 0;
            m_stalls = 0;
        end else begin
            if (st)             m_rem = MD_LAT;
            else if (m_rem > 0) m_rem--;
            if (stl)            m_stalls++;
        end
        #1;
    endtask

    task automatic clear_inputs();
        drs = 5'd0; drt = 5'd0; ern = 5'd0; mrn = 5'd0;
        d_use_rs = 1'b0; d_use_rt = 1'b0; d_muldiv = 1'b0; d_mfhilo = 1'b0;
        ewreg = 1'b0; em2reg = 1'b0; mwreg = 1'b0; mm2reg = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [4:0] drs, drt;
        logic       use_rs, use_rt, ewreg, em2reg;
        logic [4:0] ern;
        logic       mwreg, mm2reg;
        logic [4:0] mrn;
        logic [1:0] fa, fb;
        logic       wp;
    } vec_t;

    vec_t vecs[9];

    initial begin
        //            drs    drt    urs   urt   ewr   em2   ern    mwr   mm2   mrn    fa     fb     wp
        vecs[0] = '{5'd5, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 5'd5, 2'b01, 2'b00, 1'b1};
        vecs[1] = '{5'd5, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 5'd5, 2'b10, 2'b00, 1'b1};
        vecs[2] = '{5'd5, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd5, 2'b11, 2'b00, 1'b1};
        vecs[3] = '{5'd1, 5'd8, 1'b0, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 5'd0, 2'b00, 2'b00, 1'b0};
        vecs[4] = '{5'd1, 5'd8, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 5'd0, 2'b00, 2'b00, 1'b1};
        vecs[5] = '{5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 2'b00, 2'b00, 1'b1};
        vecs[6] = '{5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd9, 2'b00, 2'b10, 1'b1};
        vecs[7] = '{5'd6, 5'd6, 1'b1, 1'b1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 5'd6, 2'b10, 2'b10, 1'b0};
        vecs[8] = '{5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 5'd0, 2'b01, 2'b01, 1'b1};
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] cnt_before;

        // Reset state
        clrn = 1'b1;
        clear_inputs();
        #1;
        check("rst.md_busy",   32'(md_busy),   32'd0);
        check("rst.md_done",   32'(md_done),   32'd0);
        check("rst.stall_cnt", 32'(stall_cnt), 32'd0);
        tick();
        tick();
        clrn = 1'b0;

        // Forwarding / load-use table
        foreach (vecs[i]) begin
            drs = vecs[i].drs; drt = vecs[i].drt;
            d_use_rs = vecs[i].use_rs; d_use_rt = vecs[i].use_rt;
            ewreg = vecs[i].ewreg; em2reg = vecs[i].em2reg; ern = vecs[i].ern;
            mwreg = vecs[i].mwreg; mm2reg = vecs[i].mm2reg; mrn = vecs[i].mrn;
            d_muldiv = 1'b0; d_mfhilo = 1'b0;
            cnt_before = stall_cnt;
            #1;
            check($sformatf("vec%0d.fwda", i),    32'(fwda),    32'(vecs[i].fa));
            check($sformatf("vec%0d.fwdb", i),    32'(fwdb),    32'(vecs[i].fb));
            check($sformatf("vec%0d.wpcir", i),   32'(wpcir),   32'(vecs[i].wp));
            check($sformatf("vec%0d.dbubble", i), 32'(dbubble), 32'(!vecs[i].wp));
            tick();
            check($sformatf("vec%0d.stall_inc", i), 32'(stall_cnt - cnt_before), 32'(!vecs[i].wp));
        end

        // Mul/div issue-to-release latency with a HI/LO reader held in ID
        clear_inputs();
        d_muldiv = 1'b1;
        #1;
        check("lat.start", 32'(md_start), 32'd1);
        cmp_all("lat.T");
        tick();
        d_muldiv = 1'b0;
        d_mfhilo = 1'b1;
        for (int k = 1; k <= MD_LAT + 1; k++) begin
            #1;
            check($sformatf("lat.busy%0d", k),  32'(md_busy), 32'(k <= MD_LAT));
            check($sformatf("lat.done%0d", k),  32'(md_done), 32'(k == MD_LAT));
            check($sformatf("lat.wpcir%0d", k), 32'(wpcir),   32'(k > MD_LAT));
            cmp_all("lat");
            tick();
        end

        // Load-use and mul/div together: load-use wins, issue follows next cycle
        clear_inputs();
        ewreg = 1'b1; em2reg = 1'b1; ern = 5'd4; drs = 5'd4; d_use_rs = 1'b1;
        d_muldiv = 1'b1;
        #1;
        check("lumd.start_held", 32'(md_start), 32'd0);
        check("lumd.wpcir",      32'(wpcir),    32'd0);
        cmp_all("lumd.0");
        tick();
        ewreg = 1'b0; em2reg = 1'b0;
        #1;
        check("lumd.start", 32'(md_start), 32'd1);
        cmp_all("lumd.1");
        tick();

        // Back-to-back mul/div: the waiting op issues in the first IDLE cycle
        for (int k = 1; k <= MD_LAT + 1; k++) begin
            #1;
            check($sformatf("b2b.start%0d", k), 32'(md_start), 32'(k == MD_LAT + 1));
            check($sformatf("b2b.wpcir%0d", k), 32'(wpcir),    32'(k == MD_LAT + 1));
            cmp_all("b2b");
            tick();
        end

        // Independent instruction proceeds while busy
        clear_inputs();
        drs = 5'd7; drt = 5'd11; d_use_rs = 1'b1; d_use_rt = 1'b1;
        #1;
        check("indep.busy",  32'(md_busy), 32'd1);
        check("indep.wpcir", 32'(wpcir),   32'd1);
        cmp_all("indep");
        tick();
        repeat (8) tick();

        // Reset mid-busy: aborts the op, comb outputs still follow inputs
        clrn = 1'b1;
        m_rem = 0;
        m_stalls = 0;
        ewreg = 1'b1; em2reg = 1'b0; ern = 5'd5; drs = 5'd5;
        #1;
        check("rstmid.busy",  32'(md_busy),   32'd0);
        check("rstmid.done",  32'(md_done),   32'd0);
        check("rstmid.cnt",   32'(stall_cnt), 32'd0);
        check("rstmid.fwda",  32'(fwda),      32'd1);
        check("rstmid.wpcir", 32'(wpcir),     32'd1);
        tick();
        clrn = 1'b0;
        clear_inputs();
        for (int k = 0; k < 40; k++) begin
            #1;
            check("rstmid.no_done", 32'(md_done), 32'd0);
            cmp_all("rstmid");
            tick();
        end

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            drs = 5'($urandom_range(0, 3));
            drt = 5'($urandom_range(0, 3));
            ern = 5'($urandom_range(0, 3));
            mrn = 5'($urandom_range(0, 3));
            d_use_rs = 1'($urandom_range(0, 1));
            d_use_rt = 1'($urandom_range(0, 1));
            ewreg    = 1'($urandom_range(0, 1));
            em2reg   = 1'($urandom_range(0, 1));
            mwreg    = 1'($urandom_range(0, 1));
            mm2reg   = 1'($urandom_range(0, 1));
            d_muldiv = ($urandom_range(0, 5) == 0);
            d_mfhilo = ($urandom_range(0, 5) == 0);
            #1;
            cmp_all("rand");
            tick();
        end

        // Saturation of the stall counter
        clrn = 1'b1;
        clear_inputs();
        tick();
        clrn = 1'b0;
        ewreg = 1'b1; em2reg = 1'b1; ern = 5'd8; drt = 5'd8; d_use_rt = 1'b1;
        repeat (65534) tick();
        #1;
        check("sat.near", 32'(stall_cnt), 32'hFFFE);
        repeat (6) tick();
        #1;
        check("sat.hold", 32'(stall_cnt), 32'hFFFF);
        cmp_all("sat");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
